// File: rtl/jtkiwi_shr_pkg.sv
// Shared types and default sizes for the jtkiwi shared-RAM arbiter.
// Optional bus lock is enabled with JTKIWI_SHR_LOCK_EN.
package jtkiwi_shr_pkg;

  localparam int NP_DEF = 2;
  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/jtkiwi_shr_ram.sv
// Single-port synchronous RAM, one-cycle read latency.
// Contents are never cleared by reset.
module jtkiwi_shr_ram
  import jtkiwi_shr_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= mem[addr];
  end

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Round-robin arbiter serving NP ports onto one shared RAM.
// JTKIWI_SHR_LOCK_EN: a granted port holding lock keeps exclusive priority.
module jtkiwi_shr_arb
  import jtkiwi_shr_pkg::*;
#(
  parameter int NP = NP_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NP-1:0]    req,
  input  logic [NP-1:0]    rnw,
  input  logic [NP*AW-1:0] addr,
  input  logic [NP*DW-1:0] din,
  input  logic [NP-1:0]    lock,
  output logic [NP-1:0]    ack,
  output logic [NP*DW-1:0] dout,
  output logic             busy
);

  localparam int PW = (NP > 2) ? 2 : 1;

  state_t        state;
  logic [PW-1:0] gnt;
  logic [PW-1:0] last;
  logic [PW-1:0] sel;
  logic          any;
  logic [NP-1:0] elig;
  logic [NP-1:0] mask;
  logic [NP-1:0] cand;
  logic [AW-1:0] a_l;
  logic [DW-1:0] d_l;
  logic          rnw_l;
  logic          we;
  logic [DW-1:0] q;

  logic [AW-1:0] addr_a [NP];
  logic [DW-1:0] din_a  [NP];
  logic [DW-1:0] dout_r [NP];

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign addr_a[i] = addr[i*AW +: AW];
    assign din_a[i]  = din[i*DW +: DW];
    assign dout[i*DW +: DW] = dout_r[i];
  end

`ifdef JTKIWI_SHR_LOCK_EN
  logic          lk_on;
  logic [PW-1:0] lk_idx;

  always_comb begin
    mask = '1;
    if (lk_on && lock[lk_idx]) begin
      mask = '0;
      mask[lk_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_on  <= 1'b0;
      lk_idx <= '0;
    end else if (state == IDLE && any) begin
      lk_on  <= lock[sel];
      lk_idx <= sel;
    end else if (!lock[lk_idx]) begin
      lk_on <= 1'b0;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign mask = '1;
`endif

  assign cand = req & elig & mask;

  // scan starts just after the last winner
  always_comb begin : scan
    int            j;
    logic [PW-1:0] idx;
    sel = '0;
    any = 1'b0;
    j   = 0;
    idx = '0;
    for (int k = 1; k <= NP; k++) begin
      j = int'(last) + k;
      if (j >= NP) j = j - NP;
      idx = PW'(j);
      if (!any && cand[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  // reset on the same edge blocks a pending write
  assign we = (state == ACCESS) && !rnw_l && !rst;

  jtkiwi_shr_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (a_l),
    .din  (d_l),
    .q    (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= '0;
      busy  <= 1'b0;
      elig  <= '1;
      last  <= PW'(NP - 1);
      gnt   <= '0;
      a_l   <= '0;
      d_l   <= '0;
      rnw_l <= 1'b1;
      for (int i = 0; i < NP; i++) dout_r[i] <= '0;
    end else begin
      ack  <= '0;
      elig <= elig | ~req;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt   <= sel;
            last  <= sel;
            a_l   <= addr_a[sel];
            d_l   <= din_a[sel];
            rnw_l <= rnw[sel];
            state <= ACCESS;
            busy  <= 1'b1;
          end
        end
        ACCESS: begin
          state <= DONE;
        end
        DONE: begin
          ack[gnt]  <= 1'b1;
          elig[gnt] <= 1'b0;
          if (rnw_l) dout_r[gnt] <= q;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed plus randomized bench for jtkiwi_shr_arb (NP=2 and NP=4).
// Expected data comes from a byte-map memory model and cycle counts.
module tb_jtkiwi_shr_arb;

  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req2, rnw2, lock2, ack2;
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] din2, dout2;
  logic            busy2;

  logic [3:0]      req4, rnw4, lock4, ack4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] din4, dout4;
  logic            busy4;

  jtkiwi_shr_arb #(.NP(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req2), .rnw(rnw2), .addr(addr2),
    .din(din2), .lock(lock2), .ack(ack2), .dout(dout2), .busy(busy2)
  );

  jtkiwi_shr_arb #(.NP(4), .AW(AW), .DW(DW)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .rnw(rnw4), .addr(addr4),
    .din(din4), .lock(lock4), .ack(ack4), .dout(dout4), .busy(busy4)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem2 [int];
  logic [7:0] mem4 [int];
  logic [7:0] exp_d2 [2];
  int         wq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer2(input int p, input logic r,
                       input logic [AW-1:0] a, input logic [7:0] d);
    int   lat;
    logic b1;
    lat = 0;
    b1  = 1'b0;
    rnw2[p] = r;
    addr2[p*AW +: AW] = a;
    din2[p*DW +: DW]  = d;
    req2[p] = 1'b1;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (n == 1) b1 = busy2;
      if (ack2[p]) lat = n;
    end
    chk("xfer_busy", 32'(b1), 32'd1);
    chk("xfer_latency", 32'(lat), 32'd3);
    if (!r) mem2[a] = d;
    else exp_d2[p] = mem2[a];
    chk("xfer_dout0", 32'(dout2[7:0]), 32'(exp_d2[0]));
    chk("xfer_dout1", 32'(dout2[15:8]), 32'(exp_d2[1]));
    req2[p] = 1'b0;
    tick();
  endtask

  task automatic xfer4(input int p, input logic [AW-1:0] a,
                       input logic [7:0] d);
    int lat;
    lat = 0;
    rnw4[p] = 1'b0;
    addr4[p*AW +: AW] = a;
    din4[p*DW +: DW]  = d;
    req4[p] = 1'b1;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (ack4[p]) lat = n;
    end
    chk("xfer4_latency", 32'(lat), 32'd3);
    mem4[a] = d;
    req4[p] = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_d2[0] = 8'h00;
    exp_d2[1] = 8'h00;
  endtask

  initial begin
    int c0, c1, na, n0, a01, a02, a1;
    int ord [5];
    int cyc [5];
    logic [AW-1:0] ra;
    logic [7:0]    rd;
    req2 = '0; rnw2 = '0; lock2 = '0; addr2 = '0; din2 = '0;
    req4 = '0; rnw4 = '0; lock4 = '0; addr4 = '0; din4 = '0;
    exp_d2[0] = 8'h00;
    exp_d2[1] = 8'h00;

    // reset state
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_ack2", 32'(ack2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_dout2", 32'(dout2), 32'd0);
    chk("rst_ack4", 32'(ack4), 32'd0);
    chk("rst_dout4", 32'(dout4), 32'd0);
    rst = 1'b0;
    tick();

    // write then read at the top address
    xfer2(0, 1'b0, 13'h1FFF, 8'h5A);
    xfer2(0, 1'b1, 13'h1FFF, 8'h00);
    chk("top_addr_read", 32'(dout2[7:0]), 32'h5A);

    // contention: port 0 then port 1, twice
    xfer2(0, 1'b0, 13'h0010, 8'hA1);
    xfer2(1, 1'b0, 13'h0020, 8'hB2);
    pulse_rst();
    for (int rep = 0; rep < 2; rep++) begin
      c0 = 0; c1 = 0;
      rnw2 = 2'b11;
      addr2[0 +: AW]  = 13'h0010;
      addr2[AW +: AW] = 13'h0020;
      req2 = 2'b11;
      for (int c = 1; c <= 9; c++) begin
        tick();
        if (ack2[0]) begin c0 = c; req2[0] = 1'b0; end
        if (ack2[1]) begin c1 = c; req2[1] = 1'b0; end
      end
      chk("contend_p0_cycle", 32'(c0), 32'd3);
      chk("contend_p1_cycle", 32'(c1), 32'd6);
      chk("contend_dout", 32'(dout2), {16'd0, 8'hB2, 8'hA1});
    end
    exp_d2[0] = 8'hA1;
    exp_d2[1] = 8'hB2;

    // held request: one access only
    rnw2[1] = 1'b0;
    addr2[AW +: AW] = 13'h0040;
    din2[DW +: DW]  = 8'h33;
    req2[1] = 1'b1;
    na = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ack2[1]) begin
        na++;
        mem2[13'h0040] = 8'h33;
        din2[DW +: DW] = 8'h44;
      end
    end
    chk("held_ack_count", 32'(na), 32'd1);
    req2[1] = 1'b0;
    tick();
    xfer2(1, 1'b1, 13'h0040, 8'h00);
    xfer2(1, 1'b0, 13'h0040, 8'h44);
    xfer2(1, 1'b1, 13'h0040, 8'h00);

    // reset during ACCESS aborts the write
    xfer2(0, 1'b0, 13'h0050, 8'h11);
    rnw2[0] = 1'b0;
    addr2[0 +: AW] = 13'h0050;
    din2[0 +: DW]  = 8'hFF;
    req2[0] = 1'b1;
    tick();
    chk("abort_busy_pre", 32'(busy2), 32'd1);
    rst = 1'b1;
    req2[0] = 1'b0;
    tick();
    chk("abort_ack", 32'(ack2), 32'd0);
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_dout", 32'(dout2), 32'd0);
    rst = 1'b0;
    exp_d2[0] = 8'h00;
    exp_d2[1] = 8'h00;
    na = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ack2 != 2'b00) na++;
    end
    chk("abort_no_late_ack", 32'(na), 32'd0);
    xfer2(0, 1'b1, 13'h0050, 8'h00);

    // lock: port 0 read then write, port 1 waiting
    pulse_rst();
    lock2 = 2'b01;
    rnw2  = 2'b01;
    addr2[0 +: AW]  = 13'h0010;
    addr2[AW +: AW] = 13'h0070;
    din2[DW +: DW]  = 8'h88;
    req2  = 2'b11;
    n0 = 0; a01 = 0; a02 = 0; a1 = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (ack2[0]) begin
        n0++;
        if (n0 == 1) a01 = c;
        else a02 = c;
        req2[0] = 1'b0;
        if (n0 == 2) lock2[0] = 1'b0;
      end else if (n0 == 1 && !req2[0]) begin
        rnw2[0] = 1'b0;
        addr2[0 +: AW] = 13'h0060;
        din2[0 +: DW]  = 8'h77;
        req2[0] = 1'b1;
      end
      if (ack2[1]) begin
        a1 = c;
        req2[1] = 1'b0;
      end
    end
    lock2 = 2'b00;
    chk("lock_p0_first", 32'(a01), 32'd3);
`ifdef JTKIWI_SHR_LOCK_EN
    chk("lock_p0_second", 32'(a02), 32'd7);
    chk("lock_p1", 32'(a1), 32'd10);
`else
    chk("lock_p0_second", 32'(a02), 32'd9);
    chk("lock_p1", 32'(a1), 32'd6);
`endif
    chk("lock_read_data", 32'(dout2[7:0]), 32'hA1);
    exp_d2[0] = 8'hA1;
    mem2[13'h0060] = 8'h77;
    mem2[13'h0070] = 8'h88;
    xfer2(0, 1'b1, 13'h0070, 8'h00);
    xfer2(1, 1'b1, 13'h0060, 8'h00);

    // NP=4: continuous requests, ack order 0,1,2,3,0
    for (int p = 0; p < 4; p++)
      xfer4(p, AW'(13'h0100 + p * 13'h0111), 8'($urandom));
    pulse_rst();
    for (int p = 0; p < 4; p++) begin
      ord[p] = -1;
      cyc[p] = -1;
      addr4[p*AW +: AW] = AW'(13'h0100 + p * 13'h0111);
    end
    ord[4] = -1;
    cyc[4] = -1;
    rnw4 = 4'hF;
    req4 = 4'hF;
    na = 0;
    for (int c = 1; c <= 24 && na < 5; c++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        if (ack4[p]) begin
          if (na < 5) begin
            ord[na] = p;
            cyc[na] = c;
          end
          na++;
          chk("np4_dout", 32'(dout4[p*DW +: DW]),
              32'(mem4[int'(13'h0100 + p * 13'h0111)]));
          req4[p] = 1'b0;
        end else if (!req4[p]) begin
          req4[p] = 1'b1;
        end
      end
    end
    req4 = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("np4_order", 32'(ord[i]), 32'(i % 4));
      chk("np4_cycle", 32'(cyc[i]), 32'(3 * (i + 1)));
    end
    tick();

    // randomized single-port traffic on the NP=2 instance
    foreach (mem2[k]) wq.push_back(k);
    for (int it = 0; it < 40; it++) begin
      int p;
      p = int'($urandom_range(0, 1));
      if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0:       ra = 13'h0000;
          1:       ra = 13'h1FFF;
          default: ra = AW'($urandom);
        endcase
        rd = 8'($urandom);
        xfer2(p, 1'b0, ra, rd);
        wq.push_back(int'(ra));
      end else begin
        ra = AW'(wq[$urandom_range(0, wq.size() - 1)]);
        xfer2(p, 1'b1, ra, 8'h00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
